note_chart_sequencer: RTL and testbench
=======================================

// Module: note_chart_sequencer
// PURPOSE
//  Sending side of the per-column note-timer interface. Steps through a note chart held in
//  an external synchronous ROM and pulses noteStart[c] on the exact game tick each note is due.
//  Sits between the game-tick timer and the timer columns. Each noteStart pulse spawns one
//  falling note in column c.
// PARAMETERS
//  COLS     5   number of note columns (width of noteStart and of the chart mask)
//  ADDR_W   8   chart ROM address width; chart depth = 2**ADDR_W entries
//  DELTA_W  8   width of the per-entry tick delta
// PORTS
//  Clk         in   1                clock
//  reset       in   1                asynchronous, active-high reset
//  start       in   1                begin song from address 0 (level, sampled in IDLE only)
//  pause       in   1                while 1, gameTick is ignored (no countdown)
//  gameTick    in   1                one-cycle game-time strobe from the game timer
//  chartData   in   DELTA_W+COLS     ROM word {delta, mask}; valid 1 cycle after chartAddr
//  chartAddr   out  ADDR_W           ROM read address
//  noteStart   out  COLS             one-cycle spawn pulse per column; bit c = column c
//  songActive  out  1                1 from leaving IDLE until DONE is reached
//  songDone    out  1                1 while in DONE
//  noteCount   out  ADDR_W           number of entries emitted since start (saturating)
// BEHAVIOUR
//  Reset: state=IDLE, chartAddr=0, noteStart=0, songActive=0, songDone=0, noteCount=0,
//   ticksLeft=0, tickPend=0. Reset mid-song abandons the song immediately, with no pulse.
//  Entry {delta,mask}: mask is emitted delta ticks after the previous emit (or after start).
//   delta=0 & mask!=0 means emit on the same tick as the previous entry (chord split).
//   delta=0 & mask=0 is the end-of-chart marker.
//  States:
//   IDLE  : start=1 -> FETCH, chartAddr<=0, noteCount<=0, songActive<=1.
//   FETCH : address presented; -> WAIT (1 cycle).
//   WAIT  : latch chartData. End marker -> DONE. delta==0 -> EMIT.
//           Otherwise ticksLeft<=delta -> COUNT.
//   COUNT : per gameTick&~pause, or per pending tick (tickPend), ticksLeft-=1.
//           The tick that takes ticksLeft 1->0 goes to EMIT.
//   EMIT  : noteStart<=mask for exactly 1 cycle. noteCount+=1 (saturates at all-ones).
//           If chartAddr==2**ADDR_W-1 -> DONE, else chartAddr+=1 -> FETCH.
//   DONE  : noteStart=0, songActive=0, songDone=1. start=0 -> IDLE (songDone clears).
//  Tick loss rule: a gameTick&~pause seen in FETCH/WAIT/EMIT sets tickPend.
//   COUNT consumes tickPend before any live tick, 1 decrement per cycle.
//   At most one tick can be pending; gameTick spacing is >=4 Clk by system contract.
//  start while active is ignored. pause freezes COUNT only; FETCH/WAIT/EMIT still advance.
//  noteStart is registered; no pulse is ever wider than 1 cycle. Two consecutive
//   delta=0 entries give pulses 3 cycles apart.
//  Emit latency: the due gameTick is seen in COUNT at cycle t; noteStart is high at t+1.
// CONFIGURATION
//  NOTE_CHART_LOOP_EN defined: the end marker or the address wrap -> FETCH at chartAddr=0,
//   with noteCount cleared. songActive stays 1 and DONE is reached only by reset.
//  Not defined: end marker or wrap -> DONE as described above.
// TESTING
//  1. Reset mid-COUNT, with ROM[0]={8'd3,5'b00001}: noteStart=0, all outputs at reset
//     values, chartAddr=0 on the next edge.
//  2. ROM[0]={3,00001}, ROM[1]={0,00000}, start pulse, ticks every 8 Clk -> noteStart=00001
//     for 1 cycle, 1 Clk after the 3rd tick; then songDone=1 and noteCount=1.
//  3. ROM[0]={1,00100}, ROM[1]={0,10000}, ROM[2]=end -> two separate 1-cycle pulses,
//     3 Clk apart, on the same tick; noteCount=2.
//  4. ROM[0]={4,00010}, pause=1 across ticks 2-3 -> emit delayed by exactly 2 ticks.
//  5. gameTick asserted in the WAIT cycle for ROM[0]={1,01000} -> pulse within 2 Clk of
//     entering COUNT, with no further tick (tickPend consumed).
//  6. NOTE_CHART_LOOP_EN, ROM[0]={2,00001}, ROM[1]=end -> pulses every 2 ticks indefinitely;
//     songDone never asserts.

Source files
------------

// File: rtl/note_chart_sequencer.sv
//------------------------------------------------------------------------------
// note_chart_sequencer: walks a {delta,mask} note chart in external sync ROM and
// pulses noteStart on the due game tick. Optional looping: NOTE_CHART_LOOP_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module note_chart_sequencer #(
  parameter int COLS    = 5,
  parameter int ADDR_W  = 8,
  parameter int DELTA_W = 8
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    gameTick,
  input  logic [DELTA_W+COLS-1:0] chartData,
  output logic [ADDR_W-1:0]       chartAddr,
  output logic [COLS-1:0]         noteStart,
  output logic                    songActive,
  output logic                    songDone,
  output logic [ADDR_W-1:0]       noteCount
);

`ifdef NOTE_CHART_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_COUNT = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DELTA_W-1:0]   r_ticksLeft;
  logic                 r_tickPend;
  logic [COLS-1:0]      r_mask;

  logic [DELTA_W-1:0]   w_delta;
  logic [COLS-1:0]      w_mask;
  logic                 w_tick;
  logic                 w_step;
  logic                 w_last;
  logic                 w_end;
  logic                 w_addrLast;

  assign w_delta    = chartData[DELTA_W+COLS-1:COLS];
  assign w_mask     = chartData[COLS-1:0];
  assign w_tick     = gameTick & ~pause;
  assign w_step     = r_tickPend | w_tick;
  assign w_last     = (r_ticksLeft == DELTA_W'(1));
  assign w_end      = (w_delta == '0) && (w_mask == '0);
  assign w_addrLast = &chartAddr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_end)               w_next = LOOP_EN ? S_FETCH : S_DONE;
        else if (w_delta == '0)  w_next = S_EMIT;
        else                     w_next = S_COUNT;
      end
      S_COUNT: if (w_step && w_last) w_next = S_EMIT;
      S_EMIT:  w_next = (w_addrLast && !LOOP_EN) ? S_DONE : S_FETCH;
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      chartAddr   <= '0;
      noteStart   <= '0;
      songActive  <= 1'b0;
      songDone    <= 1'b0;
      noteCount   <= '0;
      r_ticksLeft <= '0;
      r_tickPend  <= 1'b0;
      r_mask      <= '0;
    end else begin
      r_state   <= w_next;
      noteStart <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            chartAddr  <= '0;
            noteCount  <= '0;
            songActive <= 1'b1;
            r_tickPend <= 1'b0;
          end
        end
        S_FETCH: if (w_tick) r_tickPend <= 1'b1;
        S_WAIT: begin
          if (w_tick) r_tickPend <= 1'b1;
          r_mask <= w_mask;
          if (w_end) begin
            if (LOOP_EN) begin
              chartAddr <= '0;
              noteCount <= '0;
            end else begin
              songActive <= 1'b0;
              songDone   <= 1'b1;
            end
          end else if (w_delta == '0) begin
            noteStart <= w_mask;
          end else begin
            r_ticksLeft <= w_delta;
          end
        end
        S_COUNT: begin
          // A pending tick is spent first; a coincident live tick stays pending.
          if (r_tickPend) begin
            r_tickPend  <= w_tick;
            r_ticksLeft <= r_ticksLeft - DELTA_W'(1);
          end else if (w_tick) begin
            r_ticksLeft <= r_ticksLeft - DELTA_W'(1);
          end
          if (w_step && w_last) noteStart <= r_mask;
        end
        S_EMIT: begin
          if (w_tick) r_tickPend <= 1'b1;
          if (noteCount != '1) noteCount <= noteCount + ADDR_W'(1);
          if (w_addrLast) begin
            if (LOOP_EN) begin
              chartAddr <= '0;
              noteCount <= '0;
            end else begin
              songActive <= 1'b0;
              songDone   <= 1'b1;
            end
          end else begin
            chartAddr <= chartAddr + ADDR_W'(1);
          end
        end
        S_DONE: if (!start) songDone <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_chart_sequencer.sv
//------------------------------------------------------------------------------
// tb_note_chart_sequencer: directed checks of note_chart_sequencer with a
// behavioural sync ROM. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_note_chart_sequencer;

  localparam int COLS = 5;
  localparam int ADDR_W = 8;
  localparam int DELTA_W = 8;

  logic                    Clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic                    pause = 1'b0;
  logic                    gameTick = 1'b0;
  logic [DELTA_W+COLS-1:0] chartData = '0;
  logic [ADDR_W-1:0]       chartAddr;
  logic [COLS-1:0]         noteStart;
  logic                    songActive;
  logic                    songDone;
  logic [ADDR_W-1:0]       noteCount;

  logic [DELTA_W+COLS-1:0] rom [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  // cycle-indexed logs of raw ticks and noteStart pulses
  int cyc = 0;
  int n_tick = 0;
  int tick_c [0:255];
  int n_p = 0;
  int p_c [0:63];
  int p_v [0:63];
  int wide = 0;
  int done_cnt = 0;
  int nc_at_done = 0;
  logic [COLS-1:0] prev_ns = '0;

  note_chart_sequencer #(.COLS(COLS), .ADDR_W(ADDR_W), .DELTA_W(DELTA_W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .pause(pause), .gameTick(gameTick),
    .chartData(chartData), .chartAddr(chartAddr), .noteStart(noteStart),
    .songActive(songActive), .songDone(songDone), .noteCount(noteCount)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) chartData <= rom[chartAddr];

  always @(posedge Clk) begin
    if (gameTick) begin
      tick_c[n_tick] <= cyc;
      n_tick <= n_tick + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge Clk) begin
    if (noteStart != '0) begin
      p_c[n_p] <= cyc;
      p_v[n_p] <= int'(noteStart);
      n_p <= n_p + 1;
      if (prev_ns != '0) wide <= wide + 1;
    end
    if (songDone) begin
      done_cnt <= done_cnt + 1;
      nc_at_done <= int'(noteCount);
    end
    prev_ns <= noteStart;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t);
    gameTick = t;
    @(negedge Clk);
    gameTick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic start_song();
    start = 1'b1;
    step(1'b0);
    start = 1'b0;
  endtask

  task automatic gen_ticks(input int n, input logic [15:0] pm);
    for (int i = 0; i < n; i++) begin
      idle(7);
      pause = pm[i];
      step(1'b1);
      pause = 1'b0;
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  function automatic logic [DELTA_W+COLS-1:0] ent(input int d, input int m);
    ent = {DELTA_W'(d), COLS'(m)};
  endfunction

  int bp, bt, bd;

  initial begin
    rom_clear();
    idle(2);
    check("rst_noteStart", int'(noteStart), 0);
    check("rst_chartAddr", int'(chartAddr), 0);
    check("rst_active", int'(songActive), 0);
    check("rst_done", int'(songDone), 0);
    check("rst_count", int'(noteCount), 0);
    reset = 1'b0;
    idle(2);

`ifdef NOTE_CHART_LOOP_EN
    // looping chart: pulse every 2 ticks, never done
    rom_clear();
    rom[0] = ent(2, 5'b00001);
    #1; bp = n_p; bt = n_tick; bd = done_cnt;
    start_song();
    gen_ticks(10, 16'h0);
    idle(6);
    #1;
    check("loop_pulses", n_p - bp, 5);
    check("loop_p0_lat", p_c[bp] - tick_c[bt+1], 1);
    check("loop_p4_lat", p_c[bp+4] - tick_c[bt+9], 1);
    check("loop_p4_val", p_v[bp+4], 1);
    check("loop_no_done", done_cnt - bd, 0);
    check("loop_active", int'(songActive), 1);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    idle(2);
`else
    // single note after 3 ticks, then end marker
    rom_clear();
    rom[0] = ent(3, 5'b00001);
    #1; bp = n_p; bt = n_tick; bd = done_cnt;
    start_song();
    check("t2_active", int'(songActive), 1);
    check("t2_done0", int'(songDone), 0);
    gen_ticks(3, 16'h0);
    idle(10);
    #1;
    check("t2_pulses", n_p - bp, 1);
    check("t2_val", p_v[bp], 1);
    check("t2_lat", p_c[bp] - tick_c[bt+2], 1);
    check("t2_done_seen", (done_cnt - bd) > 0 ? 1 : 0, 1);
    check("t2_count", nc_at_done, 1);
    check("t2_done_clr", int'(songDone), 0);
    check("t2_active_clr", int'(songActive), 0);
    check("t2_addr", int'(chartAddr), 1);

    // chord split: two pulses 3 cycles apart on one tick
    rom_clear();
    rom[0] = ent(1, 5'b00100);
    rom[1] = ent(0, 5'b10000);
    #1; bp = n_p; bt = n_tick;
    start_song();
    gen_ticks(1, 16'h0);
    idle(12);
    #1;
    check("t3_pulses", n_p - bp, 2);
    check("t3_v0", p_v[bp], 5'b00100);
    check("t3_v1", p_v[bp+1], 5'b10000);
    check("t3_lat", p_c[bp] - tick_c[bt], 1);
    check("t3_gap", p_c[bp+1] - p_c[bp], 3);
    check("t3_count", nc_at_done, 2);

    // pause across ticks 2 and 3 delays emit by two ticks
    rom_clear();
    rom[0] = ent(4, 5'b00010);
    #1; bp = n_p; bt = n_tick;
    start_song();
    gen_ticks(6, 16'b110);
    idle(10);
    #1;
    check("t4_pulses", n_p - bp, 1);
    check("t4_val", p_v[bp], 5'b00010);
    check("t4_lat", p_c[bp] - tick_c[bt+5], 1);

    // tick during WAIT becomes pending and is consumed in COUNT
    rom_clear();
    rom[0] = ent(1, 5'b01000);
    #1; bp = n_p; bt = n_tick;
    start_song();
    step(1'b0);
    step(1'b1);
    idle(12);
    #1;
    check("t5_pulses", n_p - bp, 1);
    check("t5_val", p_v[bp], 5'b01000);
    check("t5_lat", p_c[bp] - tick_c[bt], 2);
`endif

    // async reset in mid-COUNT abandons the song
    rom_clear();
    rom[0] = ent(3, 5'b00001);
    #1; bp = n_p;
    start_song();
    gen_ticks(2, 16'h0);
    idle(2);
    check("t1_active_pre", int'(songActive), 1);
    #2 reset = 1'b1;
    #1;
    check("t1_async_active", int'(songActive), 0);
    check("t1_async_ns", int'(noteStart), 0);
    check("t1_async_done", int'(songDone), 0);
    check("t1_async_count", int'(noteCount), 0);
    @(negedge Clk);
    reset = 1'b0;
    step(1'b0);
    check("t1_addr", int'(chartAddr), 0);
    check("t1_active", int'(songActive), 0);
    gen_ticks(2, 16'h0);
    idle(4);
    #1;
    check("t1_no_pulse", n_p - bp, 0);
    check("max_width", wide, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
